memory_interface_arbiter: RTL and testbench
===========================================

# memory_interface_arbiter

Shares one external memory port between the phoeniX core's instruction and data memory interfaces. Requests are serialised through a small FSM with fixed data-over-instruction priority and a bounded starvation guard. Each requester gets a one-cycle ready pulse when its access completes. It sits between the core and the single-ported system memory model or SRAM controller.

## Interface
- MAX_DATA_BURST, 4: consecutive data grants allowed while an instruction request is pending; the next grant then goes to instruction (range 1–15).
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- instruction_memory_interface_enable  in  1  instruction fetch request.
- instruction_memory_interface_state  in  1  READ/WRITE; always READ from the core.
- instruction_memory_interface_address  in  32  byte address.
- instruction_memory_interface_frame_mask  in  4  byte lanes.
- instruction_memory_interface_data  out  32  fetched word; valid only while instruction ready is high, else 32'bz.
- instruction_memory_interface_ready  out  1  one-cycle completion pulse.
- data_memory_interface_enable  in  1  data request.
- data_memory_interface_state  in  1  READ/WRITE.
- data_memory_interface_address  in  32  byte address.
- data_memory_interface_frame_mask  in  4  byte lanes; bit 3 = bits 7:0 … bit 0 = bits 31:24.
- data_memory_interface_data  inout  32  write data from the core; the arbiter drives read data only in the data RESPOND cycle, else high-Z.
- data_memory_interface_ready  out  1  one-cycle completion pulse.
- memory_enable  out  1  downstream request, registered.
- memory_state  out  1  READ/WRITE, registered.
- memory_address  out  32  registered.
- memory_frame_mask  out  4  registered.
- memory_write_data  out  32  registered.
- memory_read_data  in  32  valid when memory_ready is high.
- memory_ready  in  1  access complete; sampled only in a GRANT state.
- console_valid  out  1  present only with MMIO_CONSOLE_EN.
- console_char  out  8  present only with MMIO_CONSOLE_EN.

## Operation
- States: IDLE, GRANT_INSTR, GRANT_DATA, RESPOND.
- IDLE:
  - Data only pending → GRANT_DATA.
  - Instruction only pending → GRANT_INSTR.
  - Both pending → GRANT_DATA, unless starvation count == MAX_DATA_BURST, then GRANT_INSTR.
  - On entering a GRANT state, the memory_* outputs load the winner's request.
- GRANT_x: hold memory_* stable; on sampled memory_ready, capture memory_read_data, deassert memory_enable, go to RESPOND.
- RESPOND: the winner's ready is high for exactly one cycle; read data is driven to that requester; next state is IDLE.
- Starvation counter:
  - Increments on each data grant made while an instruction request is pending.
  - Clears on an instruction grant, or whenever instruction enable is low in IDLE.
  - Saturates at MAX_DATA_BURST.
- Requesters hold enable/address/state/mask/data stable until ready; enable still high at the next IDLE is a new request.
- Address passes through unmodified; no alignment check.
- memory_ready outside a GRANT state is ignored.

## Timing
- Reset values: memory_enable 0, memory_state READ, memory_address/mask/write_data 0, both ready 0, read-data outputs high-Z, console_valid 0, console_char 0, state IDLE, counter 0.
- Reset asserted mid-access: outputs return to reset values immediately; the access is abandoned and no ready is issued.
- Latency from request sampled (posedge N) with a zero-wait memory (memory_ready high in the first GRANT cycle): GRANT at N+1, RESPOND at N+2, ready visible in cycle N+2, IDLE at N+3.
- Each memory wait cycle adds one cycle of latency.
- Maximum throughput: one access per 3 cycles.
- An instruction request is serviced within (MAX_DATA_BURST+1) arbitration rounds.

## Configuration
- MMIO_CONSOLE_EN defined:
  - A data WRITE to 32'h1000_0000 goes IDLE → RESPOND directly with no memory access.
  - console_valid pulses in RESPOND with console_char = write data[7:0]; frame mask is ignored.
  - A data READ of that address returns 0.
- Undefined: no console ports; that address is an ordinary memory access.

## Structure
- Shared package: FSM state encodings, READ/WRITE, ENABLE/DISABLE, CONSOLE_ADDRESS (32'h1000_0000).
- One natural sub-module: arbiter_starvation_counter (saturating counter, clear/increment, outputs a starved flag).

## Test plan
- Instruction-only read of address 0x40 with zero-wait memory (memory_read_data 0x00000013) → memory_address 0x40 in cycle N+1; instruction ready and data 0x00000013 in cycle N+2.
- Data write 0xDEADBEEF to 0x100, mask 4'b1111, memory_ready delayed 3 cycles → memory_write_data 0xDEADBEEF held stable for 4 cycles; data ready in cycle N+5.
- Both requesting continuously, MAX_DATA_BURST=4 → grant order D,D,D,D,I, repeating; the instruction is never starved.
- Reset asserted while in GRANT_DATA → memory_enable 0 the same cycle, no ready pulse, state IDLE after reset release.
- MMIO_CONSOLE_EN: data write 0x00000041 to 0x1000_0000 → console_valid=1 with console_char 0x41 in cycle N+1, memory_enable stays 0.
- memory_ready pulsed in IDLE with no request pending → no ready output and no state change.

Source files
------------

// File: rtl/memory_interface_arbiter_pkg.sv
// rtl/memory_interface_arbiter_pkg.sv - shared encodings for the instruction/data memory arbiter
package memory_interface_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GRANT_INSTR = 2'd1,
    ST_GRANT_DATA  = 2'd2,
    ST_RESPOND     = 2'd3
  } arb_state_t;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000;
  localparam int          COUNT_W         = 4;

  function automatic logic is_console_address(input logic [31:0] address);
    return address == CONSOLE_ADDRESS;
  endfunction

endpackage

// File: rtl/memory_interface_arbiter_starvation_counter.sv
// rtl/memory_interface_arbiter_starvation_counter.sv - saturating count of data grants made over a waiting fetch
module memory_interface_arbiter_starvation_counter
  import memory_interface_arbiter_pkg::*;
#(
  parameter int MAX_COUNT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_increment,
  output logic o_starved
);

  localparam logic [COUNT_W-1:0] LP_MAX = COUNT_W'(MAX_COUNT);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_increment && (r_count != LP_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_starved = (r_count == LP_MAX);

endmodule

// File: rtl/memory_interface_arbiter.sv
// rtl/memory_interface_arbiter.sv - shares one memory port between instruction and data interfaces
// Optional console tap at CONSOLE_ADDRESS is built when MMIO_CONSOLE_EN is defined.
module memory_interface_arbiter
  import memory_interface_arbiter_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_memory_interface_enable,
  input  logic        instruction_memory_interface_state,
  input  logic [31:0] instruction_memory_interface_address,
  input  logic [3:0]  instruction_memory_interface_frame_mask,
  output logic [31:0] instruction_memory_interface_data,
  output logic        instruction_memory_interface_ready,
  input  logic        data_memory_interface_enable,
  input  logic        data_memory_interface_state,
  input  logic [31:0] data_memory_interface_address,
  input  logic [3:0]  data_memory_interface_frame_mask,
  inout  wire  [31:0] data_memory_interface_data,
  output logic        data_memory_interface_ready,
  output logic        memory_enable,
  output logic        memory_state,
  output logic [31:0] memory_address,
  output logic [3:0]  memory_frame_mask,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data,
  input  logic        memory_ready
`ifdef MMIO_CONSOLE_EN
  ,
  output logic        console_valid,
  output logic [7:0]  console_char
`endif
);

  arb_state_t  r_state;
  logic        r_instr_ready;
  logic        r_data_ready;
  logic        r_winner_read;
  logic [31:0] r_read_data;

  logic        w_data_go;
  logic        w_instr_go;
  logic        w_clear;
  logic        w_increment;
  logic        w_starved;
  logic [31:0] w_core_wdata;

  assign w_core_wdata = data_memory_interface_data;

  // Data wins ties unless the fetch has already waited out a full burst.
  always_comb begin
    w_data_go  = 1'b0;
    w_instr_go = 1'b0;
    if (r_state == ST_IDLE) begin
      if (data_memory_interface_enable &&
          !(instruction_memory_interface_enable && w_starved)) begin
        w_data_go = 1'b1;
      end else if (instruction_memory_interface_enable) begin
        w_instr_go = 1'b1;
      end
    end
  end

  assign w_increment = w_data_go && instruction_memory_interface_enable;
  assign w_clear     = w_instr_go ||
                       ((r_state == ST_IDLE) && !instruction_memory_interface_enable);

  memory_interface_arbiter_starvation_counter #(
    .MAX_COUNT (MAX_DATA_BURST)
  ) u_starvation_counter (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_clear     (w_clear),
    .i_increment (w_increment),
    .o_starved   (w_starved)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_instr_ready     <= 1'b0;
      r_data_ready      <= 1'b0;
      r_winner_read     <= 1'b0;
      r_read_data       <= '0;
      memory_enable     <= DISABLE;
      memory_state      <= READ;
      memory_address    <= '0;
      memory_frame_mask <= '0;
      memory_write_data <= '0;
`ifdef MMIO_CONSOLE_EN
      console_valid     <= 1'b0;
      console_char      <= '0;
`endif
    end else begin
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
`ifdef MMIO_CONSOLE_EN
      console_valid <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_data_go) begin
            r_winner_read <= (data_memory_interface_state == READ);
`ifdef MMIO_CONSOLE_EN
            if (is_console_address(data_memory_interface_address)) begin
              // Console accesses never reach memory; reads of it return zero.
              r_state      <= ST_RESPOND;
              r_data_ready <= 1'b1;
              r_read_data  <= '0;
              if (data_memory_interface_state == WRITE) begin
                console_valid <= 1'b1;
                console_char  <= w_core_wdata[7:0];
              end
            end else
`endif
            begin
              r_state           <= ST_GRANT_DATA;
              memory_enable     <= ENABLE;
              memory_state      <= data_memory_interface_state;
              memory_address    <= data_memory_interface_address;
              memory_frame_mask <= data_memory_interface_frame_mask;
              memory_write_data <= w_core_wdata;
            end
          end else if (w_instr_go) begin
            r_state           <= ST_GRANT_INSTR;
            r_winner_read     <= 1'b1;
            memory_enable     <= ENABLE;
            memory_state      <= instruction_memory_interface_state;
            memory_address    <= instruction_memory_interface_address;
            memory_frame_mask <= instruction_memory_interface_frame_mask;
            memory_write_data <= '0;
          end
        end
        ST_GRANT_INSTR, ST_GRANT_DATA: begin
          if (memory_ready) begin
            r_read_data   <= memory_read_data;
            memory_enable <= DISABLE;
            r_state       <= ST_RESPOND;
            if (r_state == ST_GRANT_DATA) begin
              r_data_ready <= 1'b1;
            end else begin
              r_instr_ready <= 1'b1;
            end
          end
        end
        ST_RESPOND: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instruction_memory_interface_ready = r_instr_ready;
  assign data_memory_interface_ready        = r_data_ready;
  assign instruction_memory_interface_data  = r_instr_ready ? r_read_data : 32'bz;
  assign data_memory_interface_data         = (r_data_ready && r_winner_read) ? r_read_data : 32'bz;

endmodule

// File: tb/tb_memory_interface_arbiter.sv
// tb/tb_memory_interface_arbiter.sv - directed self-checking bench for memory_interface_arbiter
module tb_memory_interface_arbiter;

  logic        clk;
  logic        reset;
  logic        i_en;
  logic        i_state;
  logic [31:0] i_addr;
  logic [3:0]  i_mask;
  wire  [31:0] i_data;
  logic        i_ready;
  logic        d_en;
  logic        d_state;
  logic [31:0] d_addr;
  logic [3:0]  d_mask;
  wire  [31:0] d_data;
  logic        d_ready;
  logic        m_en;
  logic        m_state;
  logic [31:0] m_addr;
  logic [3:0]  m_mask;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
`ifdef MMIO_CONSOLE_EN
  logic        c_valid;
  logic [7:0]  c_char;
`endif

  logic        tb_drive;
  logic [31:0] tb_wdata;
  assign d_data = tb_drive ? tb_wdata : 32'bz;

  int n_checks = 0;
  int n_pass   = 0;

  memory_interface_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk                                     (clk),
    .reset                                   (reset),
    .instruction_memory_interface_enable     (i_en),
    .instruction_memory_interface_state      (i_state),
    .instruction_memory_interface_address    (i_addr),
    .instruction_memory_interface_frame_mask (i_mask),
    .instruction_memory_interface_data       (i_data),
    .instruction_memory_interface_ready      (i_ready),
    .data_memory_interface_enable            (d_en),
    .data_memory_interface_state             (d_state),
    .data_memory_interface_address           (d_addr),
    .data_memory_interface_frame_mask        (d_mask),
    .data_memory_interface_data              (d_data),
    .data_memory_interface_ready             (d_ready),
    .memory_enable                           (m_en),
    .memory_state                            (m_state),
    .memory_address                          (m_addr),
    .memory_frame_mask                       (m_mask),
    .memory_write_data                       (m_wdata),
    .memory_read_data                        (m_rdata),
    .memory_ready                            (m_ready)
`ifdef MMIO_CONSOLE_EN
    ,
    .console_valid                           (c_valid),
    .console_char                            (c_char)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; i_en = 0; i_state = 0; i_addr = 0; i_mask = 0;
    d_en = 0; d_state = 0; d_addr = 0; d_mask = 0;
    m_rdata = 0; m_ready = 0; tb_drive = 0; tb_wdata = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_m_en", 32'(m_en), 0);
    check_eq("rst_m_state", 32'(m_state), 0);
    check_eq("rst_m_addr", m_addr, 0);
    check_eq("rst_m_wdata", m_wdata, 0);
    check_eq("rst_readys", {30'd0, i_ready, d_ready}, 0);
    reset = 1'b0;
    tick();

    // instruction read, zero-wait memory
    i_en = 1; i_state = 0; i_addr = 32'h40; i_mask = 4'hF;
    m_rdata = 32'h0000_0013; m_ready = 1;
    tick();
    check_eq("ifetch_m_en", 32'(m_en), 1);
    check_eq("ifetch_m_addr", m_addr, 32'h40);
    check_eq("ifetch_early_ready", 32'(i_ready), 0);
    tick();
    check_eq("ifetch_ready", 32'(i_ready), 1);
    check_eq("ifetch_data", i_data, 32'h0000_0013);
    check_eq("ifetch_m_en_off", 32'(m_en), 0);
    check_eq("ifetch_no_dready", 32'(d_ready), 0);
    i_en = 0; m_ready = 0;
    tick();
    check_eq("ifetch_ready_pulse", 32'(i_ready), 0);

    // data write with three memory wait cycles
    d_en = 1; d_state = 1; d_addr = 32'h100; d_mask = 4'hF;
    tb_drive = 1; tb_wdata = 32'hDEAD_BEEF;
    tick();
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("dwr_wdata_%0d", k), m_wdata, 32'hDEAD_BEEF);
      check_eq($sformatf("dwr_hold_%0d", k), {30'd0, m_en, d_ready}, 32'd2);
      if (k == 4) m_ready = 1;
      tick();
    end
    check_eq("dwr_ready", 32'(d_ready), 1);
    check_eq("dwr_m_state", 32'(m_state), 1);
    d_en = 0; tb_drive = 0; m_ready = 0;
    tick();

    // both requesting continuously: D,D,D,D,I repeating
    i_en = 1; i_addr = 32'h200; d_en = 1; d_state = 0; d_addr = 32'h300;
    m_ready = 1; m_rdata = 32'h1111_0000;
    for (int g = 0; g < 10; g++) begin
      tick();
      check_eq($sformatf("order_addr_%0d", g), m_addr, (g % 5 == 4) ? 32'h200 : 32'h300);
      tick();
      check_eq($sformatf("order_ready_%0d", g), {30'd0, i_ready, d_ready},
               (g % 5 == 4) ? 32'd2 : 32'd1);
      if (g % 5 != 4) check_eq($sformatf("order_drd_%0d", g), d_data, 32'h1111_0000);
      tick();
    end
    i_en = 0; d_en = 0; m_ready = 0;
    tick();

    // reset asserted while in GRANT_DATA
    d_en = 1; d_state = 0; d_addr = 32'h500;
    tick();
    check_eq("rstmid_granted", 32'(m_en), 1);
    reset = 1;
    #1;
    check_eq("rstmid_m_en", 32'(m_en), 0);
    check_eq("rstmid_m_addr", m_addr, 0);
    d_en = 0;
    tick();
    reset = 0;
    m_ready = 1;
    tick();
    check_eq("rstmid_no_ready", {30'd0, i_ready, d_ready}, 0);
    m_ready = 0;
    i_en = 1; i_addr = 32'h600;
    tick();
    check_eq("rstmid_idle_grant", {m_addr[30:0], m_en}, {31'h600, 1'b1});
    m_ready = 1;
    tick();
    check_eq("rstmid_iready", 32'(i_ready), 1);
    i_en = 0; m_ready = 0;
    tick();

    // memory_ready in IDLE with nothing pending
    m_ready = 1;
    tick();
    check_eq("idle_ready_ignored", {29'd0, m_en, i_ready, d_ready}, 0);
    tick();
    check_eq("idle_ready_ignored2", {29'd0, m_en, i_ready, d_ready}, 0);
    m_ready = 0;

    // console address
    d_en = 1; d_state = 1; d_addr = 32'h1000_0000; tb_drive = 1; tb_wdata = 32'h0000_0041;
    tick();
`ifdef MMIO_CONSOLE_EN
    check_eq("con_valid", 32'(c_valid), 1);
    check_eq("con_char", 32'(c_char), 32'h41);
    check_eq("con_no_mem", 32'(m_en), 0);
    check_eq("con_ready", 32'(d_ready), 1);
    d_en = 0; tb_drive = 0;
    tick();
    check_eq("con_valid_pulse", 32'(c_valid), 0);
`else
    check_eq("con_plain_m_en", 32'(m_en), 1);
    check_eq("con_plain_addr", m_addr, 32'h1000_0000);
    check_eq("con_plain_wdata", m_wdata, 32'h0000_0041);
    m_ready = 1;
    tick();
    check_eq("con_plain_ready", 32'(d_ready), 1);
    d_en = 0; tb_drive = 0; m_ready = 0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
